fir_filter_param: RTL and testbench



---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_round_sat.sv | 39 +++
 rtl/fir_filter_param.sv | 135 +++++++++++++
 tb/tb_fir_filter_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: accumulator sizing, default coefficient value,
// output clip bounds and sample/coefficient/accumulator types for the
// reference configuration (4 taps, 16-bit samples, Q1.7 coefficients).
package fir_pkg;

    localparam int DEF_TAPS   = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_FRAC_W = 7;

    // Full-precision accumulator: product width plus growth for the tap sum.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Moving-average coefficient: unity gain split evenly across the taps.
    function automatic int default_coef(input int frac_w, input int taps);
        return (1 << frac_w) / taps;
    endfunction

    localparam int DEF_ACC_W = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_TAPS);

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    localparam sample_t SAMPLE_MAX = sample_t'(2**(DEF_DATA_W-1) - 1);
    localparam sample_t SAMPLE_MIN = sample_t'(-(2**(DEF_DATA_W-1)));

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and clip to OUT_W
// signed bits. sat_o flags a clipped result. Requires IN_W >= OUT_W and
// SHIFT >= 1.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int IN_W  = 26,
    parameter int OUT_W = 16,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    // One guard bit so adding the half-LSB can never wrap.
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT-1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shr;

    // Round, scale down, then clip to the output range.
    always_comb begin
        rnd    = {acc_i[IN_W-1], acc_i} + HALF;
        shr    = rnd >>> SHIFT;
        data_o = shr[OUT_W-1:0];
        sat_o  = 1'b0;
        if (shr > MAXV) begin
            data_o = MAXV[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (shr < MINV) begin
            data_o = MINV[OUT_W-1:0];
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_param.sv
// Parametrised direct-form FIR: stage 1 is the sample delay line, stage 2
// registers the rounded/saturated tap sum. Two-edge latency, one sample
// per cycle. Define FIR_COEF_LOAD_EN to make the coefficients writable;
// otherwise they are the fixed moving-average set and coef_* are ignored.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int FRAC_W = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     flush,
    input  logic                     coef_wr,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     primed,
    output logic                     sat
);

    localparam int AW    = $clog2(TAPS);
    localparam int CW    = $clog2(TAPS+1);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);

    localparam logic [COEF_W-1:0] C_DEF  = COEF_W'(default_coef(FRAC_W, TAPS));
    localparam logic [CW-1:0]     TAPS_C = CW'(TAPS);

    // x[0] is the newest sample; index k holds the sample k acceptances old.
    logic [TAPS-1:0][DATA_W-1:0] x_q, x_d;
    logic [TAPS-1:0][COEF_W-1:0] c;
    logic [CW-1:0]               cnt_q, cnt_d;
    // [0]: a sample sits in the delay line awaiting stage 2, [1]: out_valid.
    logic [1:0]                  vld_pipe_q, vld_pipe_d;
    logic                        primed_q, primed_d;
    logic                        sat_q, sat_d;
    logic [DATA_W-1:0]           data_out_q, data_out_d;

    logic signed [ACC_W-1:0]     acc;
    logic signed [DATA_W-1:0]    rs_data;
    logic                        rs_sat;

`ifdef FIR_COEF_LOAD_EN
    localparam logic [AW:0] TAPS_A = TAPS[AW:0];

    logic [TAPS-1:0][COEF_W-1:0] c_q, c_d;

    // Coefficient write port; out-of-range addresses are dropped.
    always_comb begin
        c_d = c_q;
        if (coef_wr && ({1'b0, coef_addr} < TAPS_A))
            c_d[coef_addr] = coef_data;
    end

    // Coefficient storage, back to the moving-average set on reset.
    always_ff @(posedge clk) begin
        if (reset) c_q <= {TAPS{C_DEF}};
        else       c_q <= c_d;
    end

    assign c = c_q;
`else
    logic coef_unused;
    assign coef_unused = ^{coef_wr, coef_addr, coef_data};
    assign c = {TAPS{C_DEF}};
`endif

    // Multiply-accumulate across all taps at full precision.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++)
            acc = acc + ACC_W'($signed(x_q[k])) * ACC_W'($signed(c[k]));
    end

    fir_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (FRAC_W)
    ) u_round_sat (
        .acc_i  (acc),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // Next-state: delay line shift, fill counter and stage-2 output capture.
    // flush beats in_valid and kills the result waiting in stage 2.
    always_comb begin
        x_d        = x_q;
        cnt_d      = cnt_q;
        vld_pipe_d = {vld_pipe_q[0] & ~flush, 1'b0};
        primed_d   = primed_q | (vld_pipe_q[0] && (cnt_q == TAPS_C));
        if (flush) begin
            x_d      = '0;
            cnt_d    = '0;
            primed_d = 1'b0;
        end else if (in_valid) begin
            x_d           = {x_q[TAPS-2:0], data_in};
            vld_pipe_d[0] = 1'b1;
            if (cnt_q != TAPS_C)
                cnt_d = cnt_q + 1'b1;
        end
        data_out_d = vld_pipe_d[1] ? rs_data : data_out_q;
        sat_d      = vld_pipe_d[1] & rs_sat;
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            cnt_q      <= '0;
            vld_pipe_q <= '0;
            primed_q   <= 1'b0;
            sat_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            vld_pipe_q <= vld_pipe_d;
            primed_q   <= primed_d;
            sat_q      <= sat_d;
            data_out_q <= data_out_d;
        end
    end

    assign out_valid = vld_pipe_q[1];
    assign data_out  = data_out_q;
    assign primed    = primed_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param (TAPS=4, DATA_W=16, COEF_W=8,
// FRAC_W=7, default coefficient 32). A TAPS=5 instance checks that a write
// to an address beyond the last tap is dropped.
module tb_fir_filter_param;
    import fir_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic signed [15:0] data_in = '0;
    logic               flush = 1'b0;
    logic               coef_wr = 1'b0;
    logic [1:0]         coef_addr = '0;
    logic signed [7:0]  coef_data = '0;
    logic               out_valid, primed, sat;
    logic signed [15:0] data_out;

    logic               coef_wr5 = 1'b0;
    logic [2:0]         coef_addr5 = '0;
    logic               out_valid5, primed5, sat5;
    logic signed [15:0] data_out5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_filter_param #(.TAPS(4), .DATA_W(16), .COEF_W(8), .FRAC_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .flush     (flush),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .data_out  (data_out),
        .primed    (primed),
        .sat       (sat)
    );

    fir_filter_param #(.TAPS(5), .DATA_W(16), .COEF_W(8), .FRAC_W(7)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .flush     (flush),
        .coef_wr   (coef_wr5),
        .coef_addr (coef_addr5),
        .coef_data (coef_data),
        .out_valid (out_valid5),
        .data_out  (data_out5),
        .primed    (primed5),
        .sat       (sat5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int val);
        coef_wr   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = 8'(val);
        tick();
        coef_wr   = 1'b0;
    endtask

    // Back-to-back samples; checks valid/data/sat/primed after every edge.
    // pr0 = samples accepted since the last flush/reset before this stream.
    task automatic stream(input string tag, input int n, input int v[8],
                          input int e[8], input int satmask, input int pr0);
        for (int i = 0; i <= n; i++) begin
            in_valid = (i < n);
            data_in  = (i < n) ? 16'(v[i]) : 16'sd0;
            tick();
            chk({tag, "_primed"}, primed, (pr0 + i >= 4) ? 1 : 0);
            if (i == 0) begin
                chk({tag, "_first_valid"}, out_valid, 0);
            end else begin
                chk({tag, "_valid"}, out_valid, 1);
                chk({tag, "_data"}, data_out, e[i-1]);
                chk({tag, "_sat"}, sat, satmask[i-1]);
            end
        end
        in_valid = 1'b0;
        tick();
        chk({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_primed", primed, 0);
        chk("rst_sat", sat, 0);
        reset = 1'b0;

        // Impulse through the moving average; primed with the 4th output.
        stream("impulse", 5, '{128, 0, 0, 0, 0, 0, 0, 0}, '{32, 32, 32, 32, 0, 0, 0, 0}, 0, 0);

        // Step response, then an isolated sample after a gap.
        do_flush();
        stream("step", 4, '{100, 100, 100, 100, 0, 0, 0, 0}, '{25, 50, 75, 100, 0, 0, 0, 0}, 0, 0);
        tick();
        chk("gap_valid", out_valid, 0);
        stream("gap", 1, '{100, 0, 0, 0, 0, 0, 0, 0}, '{100, 0, 0, 0, 0, 0, 0, 0}, 0, 4);

        // Flush one cycle after a sample: result discarded, data_out kept.
        in_valid = 1'b1;
        data_in  = 16'sd128;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        chk("flush_valid_a", out_valid, 0);
        tick();
        chk("flush_valid_b", out_valid, 0);
        chk("flush_primed", primed, 0);
        chk("flush_keep_data", data_out, 100);
        stream("post_flush", 1, '{128, 0, 0, 0, 0, 0, 0, 0}, '{32, 0, 0, 0, 0, 0, 0, 0}, 0, 1);

        // flush together with in_valid: the sample is dropped.
        do_flush();
        in_valid = 1'b1;
        data_in  = 16'sd5000;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        chk("flush_win_valid", out_valid, 0);
        stream("flush_win", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);

        // Coefficient write in the same cycle as a sample.
        do_flush();
        coef_wr   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 8'sd64;
        in_valid  = 1'b1;
        data_in   = 16'sd100;
        tick();
        coef_wr   = 1'b0;
        in_valid  = 1'b0;
        chk("collide_valid0", out_valid, 0);
        tick();
        chk("collide_valid1", out_valid, 1);
`ifdef FIR_COEF_LOAD_EN
        chk("collide_data", data_out, 50);

        // Rounding with a single active tap of 0.5.
        wr_coef(1, 0);
        wr_coef(2, 0);
        wr_coef(3, 0);
        do_flush();
        stream("round", 3, '{1, -1, 3, 0, 0, 0, 0, 0}, '{1, 0, 2, 0, 0, 0, 0, 0}, 0, 0);

        // Saturation with all coefficients at the positive limit.
        for (int k = 0; k < 4; k++) wr_coef(k, 127);
        do_flush();
        stream("sat_pos", 4, '{32767, 32767, 32767, 32767, 0, 0, 0, 0},
               '{32511, SAMPLE_MAX, SAMPLE_MAX, SAMPLE_MAX, 0, 0, 0, 0}, 4'b1110, 0);
        stream("sat_neg", 4, '{-32768, -32768, -32768, -32768, 0, 0, 0, 0},
               '{SAMPLE_MAX, -2, SAMPLE_MIN, SAMPLE_MIN, 0, 0, 0, 0}, 4'b1101, 4);
`else
        chk("collide_ignored", data_out, 25);
`endif

        // Reset with a sample in flight: no output, state and coefs cleared.
        in_valid = 1'b1;
        data_in  = 16'sd128;
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_data", data_out, 0);
        chk("midrst_primed", primed, 0);
        chk("midrst_sat", sat, 0);
        tick();
        chk("midrst_valid_b", out_valid, 0);
        stream("post_rst", 1, '{128, 0, 0, 0, 0, 0, 0, 0}, '{32, 0, 0, 0, 0, 0, 0, 0}, 0, 0);

        // Write to address 5 on the 5-tap instance must not land anywhere.
        coef_wr5   = 1'b1;
        coef_addr5 = 3'd5;
        coef_data  = 8'sd127;
        tick();
        coef_wr5   = 1'b0;
        do_flush();
        for (int i = 0; i <= 5; i++) begin
            in_valid = (i < 5);
            data_in  = (i == 0) ? 16'sd128 : 16'sd0;
            tick();
            if (i > 0) begin
                chk("oob_valid", out_valid5, 1);
                chk("oob_data", data_out5, 25);
            end
        end
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
